iteration_frame_packer: RTL and testbench

ITERATION_FRAME_PACKER -- requirements
Module: iteration_frame_packer

---
 rtl/iteration_frame_packer_pkg.sv | 31 +++
 rtl/iteration_frame_packer.sv | 110 +++++++++++
 tb/tb_iteration_frame_packer.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/iteration_frame_packer_pkg.sv
// Frame constants, state encoding and payload byte selection for the
// sensor-iteration frame path (octo_manager -> packer -> UART).
package iteration_frame_packer_pkg;

    localparam int PAYLOAD_LEN  = 34;
    localparam int FRAME_LEN    = 37;
    localparam int PAYLOAD_BITS = PAYLOAD_LEN * 8;

    localparam logic [7:0] SYNC0_DEFAULT = 8'hAA;
    localparam logic [7:0] SYNC1_DEFAULT = 8'h55;
    localparam logic [5:0] LAST_IDX      = 6'(PAYLOAD_LEN - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SYNC0_ST = 3'd1,
        SYNC1_ST = 3'd2,
        PAYLOAD  = 3'd3,
        CKSUM    = 3'd4,
        RELEASE  = 3'd5,
        WAIT_LOW = 3'd6
    } state_e;

    // Byte k of the payload sits at bits [271-8k -: 8] (byte 0 is the MSB byte).
    function automatic logic [7:0] payload_byte(
        input logic [PAYLOAD_BITS-1:0] shadow,
        input logic [5:0]              idx
    );
        return shadow[(PAYLOAD_BITS - 1) - 8 * int'(idx) -: 8];
    endfunction

endpackage

// File: rtl/iteration_frame_packer.sv
// Packs one captured 34-byte sensor-iteration set into a 37-byte sync/payload/XOR
// frame for the UART byte transmitter, then pulses reset_parser back to octo_manager.
module iteration_frame_packer
    import iteration_frame_packer_pkg::*;
#(
    parameter logic [7:0] SYNC0 = SYNC0_DEFAULT,
    parameter logic [7:0] SYNC1 = SYNC1_DEFAULT
) (
    input  logic                    clk_12MHz,
    input  logic                    reset,
    input  logic                    data_avl,
    input  logic [PAYLOAD_BITS-1:0] sensor_iterations,
    output logic                    reset_parser,
    output logic [7:0]              byte_data,
    output logic                    byte_valid,
    input  logic                    byte_ready,
    output logic                    busy
);

    state_e                  state_q, state_d;
    logic [PAYLOAD_BITS-1:0] shadow_q, shadow_d;
    logic [7:0]              cksum_q, cksum_d;
    logic [5:0]              idx_q, idx_d;
    logic [7:0]              byte_data_q, byte_data_d;
    logic                    byte_valid_q, byte_valid_d;
    logic                    reset_parser_q, reset_parser_d;
    logic                    busy_q, busy_d;
    logic                    xfer;

    assign xfer = byte_valid_q & byte_ready;

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        cksum_d  = cksum_q;
        idx_d    = idx_q;

        unique case (state_q)
            IDLE: begin
                if (data_avl) begin
                    shadow_d = sensor_iterations;
                    cksum_d  = 8'h00;
                    idx_d    = 6'd0;
                    state_d  = SYNC0_ST;
                end
            end
            SYNC0_ST: if (xfer) state_d = SYNC1_ST;
            SYNC1_ST: if (xfer) state_d = PAYLOAD;
            PAYLOAD: begin
                if (xfer) begin
                    // Fold the byte in as it leaves so CKSUM can present the result immediately.
                    cksum_d = cksum_q ^ byte_data_q;
                    if (idx_q == LAST_IDX) begin
                        state_d = CKSUM;
                    end else begin
                        idx_d = idx_q + 6'd1;
                    end
                end
            end
            CKSUM:    if (xfer) state_d = RELEASE;
            RELEASE:  state_d = WAIT_LOW;
            WAIT_LOW: if (!data_avl) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they are registered alongside it.
    always_comb begin
        byte_data_d = 8'h00;
        unique case (state_d)
            SYNC0_ST: byte_data_d = SYNC0;
            SYNC1_ST: byte_data_d = SYNC1;
            PAYLOAD:  byte_data_d = payload_byte(shadow_d, idx_d);
            CKSUM:    byte_data_d = cksum_d;
            default:  byte_data_d = 8'h00;
        endcase
        byte_valid_d   = (state_d == SYNC0_ST) || (state_d == SYNC1_ST) ||
                         (state_d == PAYLOAD)  || (state_d == CKSUM);
        reset_parser_d = (state_d == RELEASE);
        busy_d         = (state_d != IDLE);
    end

    always_ff @(posedge clk_12MHz) begin
        if (reset) begin
            state_q        <= IDLE;
            shadow_q       <= '0;
            cksum_q        <= 8'h00;
            idx_q          <= 6'd0;
            byte_data_q    <= 8'h00;
            byte_valid_q   <= 1'b0;
            reset_parser_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            shadow_q       <= shadow_d;
            cksum_q        <= cksum_d;
            idx_q          <= idx_d;
            byte_data_q    <= byte_data_d;
            byte_valid_q   <= byte_valid_d;
            reset_parser_q <= reset_parser_d;
            busy_q         <= busy_d;
        end
    end

    assign byte_data    = byte_data_q;
    assign byte_valid   = byte_valid_q;
    assign reset_parser = reset_parser_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_iteration_frame_packer.sv
// Directed bench for iteration_frame_packer: captures transferred bytes and
// reset_parser pulses, and compares them with hand-built expected frames.
module tb_iteration_frame_packer;

    logic         clk_12MHz = 1'b0;
    logic         reset = 1'b1;
    logic         data_avl = 1'b0;
    logic [271:0] sensor_iterations = '0;
    logic         reset_parser;
    logic [7:0]   byte_data;
    logic         byte_valid;
    logic         byte_ready = 1'b1;
    logic         busy;

    int tests_run = 0;
    int tests_failed = 0;

    logic [7:0] rx_q[$];
    int         rp_count = 0;
    bit         random_ready = 1'b0;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;

    iteration_frame_packer dut (
        .clk_12MHz         (clk_12MHz),
        .reset             (reset),
        .data_avl          (data_avl),
        .sensor_iterations (sensor_iterations),
        .reset_parser      (reset_parser),
        .byte_data         (byte_data),
        .byte_valid        (byte_valid),
        .byte_ready        (byte_ready),
        .busy              (busy)
    );

    always #5 clk_12MHz = ~clk_12MHz;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Posedge reads see pre-edge values, i.e. exactly what the DUT samples.
    always @(posedge clk_12MHz) begin
        if (prev_stall && !reset) begin
            check_eq("stall_valid", {31'd0, byte_valid}, 32'd1);
            check_eq("stall_data", {24'd0, byte_data}, {24'd0, prev_data});
        end
        if (!reset && byte_valid && byte_ready) rx_q.push_back(byte_data);
        if (!reset && reset_parser) rp_count++;
        prev_stall = !reset && byte_valid && !byte_ready;
        prev_data  = byte_data;
    end

    always @(negedge clk_12MHz) begin
        byte_ready = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    function automatic logic [271:0] counting_payload();
        logic [271:0] p;
        for (int k = 0; k < 34; k++) p[271 - 8*k -: 8] = 8'(k + 1);
        return p;
    endfunction

    task automatic wait_rp(input int target, input int budget, input string tag);
        int n = 0;
        while (rp_count < target && n < budget) begin
            @(negedge clk_12MHz);
            n++;
        end
        if (rp_count < target) check_eq({tag, "_timeout"}, 32'(rp_count), 32'(target));
    endtask

    task automatic wait_bytes(input int target, input int budget, input string tag);
        int n = 0;
        while (rx_q.size() < target && n < budget) begin
            @(negedge clk_12MHz);
            n++;
        end
        if (rx_q.size() < target) check_eq({tag, "_timeout"}, 32'(rx_q.size()), 32'(target));
    endtask

    // Compares frame number f in rx_q against SYNC, payload bytes, XOR checksum.
    task automatic check_frame(input logic [271:0] p, input int f, input string tag);
        logic [7:0] exp_b;
        logic [7:0] ck = 8'h00;
        int         base = f * 37;
        if (rx_q.size() < base + 37) begin
            check_eq({tag, "_len"}, 32'(rx_q.size()), 32'(base + 37));
            return;
        end
        for (int i = 0; i < 37; i++) begin
            if (i == 0) exp_b = 8'hAA;
            else if (i == 1) exp_b = 8'h55;
            else if (i < 36) begin
                exp_b = p[271 - 8*(i-2) -: 8];
                ck ^= exp_b;
            end else exp_b = ck;
            check_eq($sformatf("%s_b%0d", tag, i), {24'd0, rx_q[base + i]}, {24'd0, exp_b});
        end
    endtask

    task automatic run_frame(input logic [271:0] p, input string tag);
        rx_q.delete();
        rp_count = 0;
        sensor_iterations = p;
        data_avl = 1'b1;
        wait_rp(1, 600, tag);
        data_avl = 1'b0;
        repeat (3) @(negedge clk_12MHz);
        check_eq({tag, "_rp"}, 32'(rp_count), 32'd1);
        check_eq({tag, "_nbytes"}, 32'(rx_q.size()), 32'd37);
        check_frame(p, 0, tag);
    endtask

    initial begin
        logic [271:0] cnt_p;
        cnt_p = counting_payload();

        repeat (3) @(negedge clk_12MHz);
        check_eq("rst_valid", {31'd0, byte_valid}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_rp", {31'd0, reset_parser}, 32'd0);
        check_eq("rst_data", {24'd0, byte_data}, 32'd0);

        // Reset and data_avl together: no capture until reset drops.
        data_avl = 1'b1;
        @(negedge clk_12MHz);
        check_eq("rst_avl_busy", {31'd0, busy}, 32'd0);
        data_avl = 1'b0;
        reset = 1'b0;
        @(negedge clk_12MHz);
        check_eq("idle_busy", {31'd0, busy}, 32'd0);

        run_frame('0, "zero");
        $display("[TB] frame zero: %0d bytes, %0d reset_parser pulses", rx_q.size(), rp_count);

        run_frame(cnt_p, "count");
        check_eq("count_cksum", {24'd0, rx_q[36]}, 32'h23);
        $display("[TB] frame count: checksum %02h", rx_q[36]);

        random_ready = 1'b1;
        run_frame(cnt_p, "rand");
        random_ready = 1'b0;
        $display("[TB] frame rand: %0d bytes under random byte_ready", rx_q.size());

        // data_avl held high: exactly one frame until it falls and rises again.
        rx_q.delete();
        rp_count = 0;
        sensor_iterations = cnt_p;
        data_avl = 1'b1;
        repeat (200) @(negedge clk_12MHz);
        check_eq("hold_rp", 32'(rp_count), 32'd1);
        check_eq("hold_nbytes", 32'(rx_q.size()), 32'd37);
        check_eq("hold_busy", {31'd0, busy}, 32'd1);
        data_avl = 1'b0;
        repeat (2) @(negedge clk_12MHz);
        check_eq("hold_idle", {31'd0, busy}, 32'd0);
        data_avl = 1'b1;
        wait_rp(2, 600, "hold2");
        data_avl = 1'b0;
        repeat (3) @(negedge clk_12MHz);
        check_eq("hold2_nbytes", 32'(rx_q.size()), 32'd74);
        check_frame(cnt_p, 1, "hold2");
        $display("[TB] frame hold: %0d pulses over %0d bytes", rp_count, rx_q.size());

        // Input changes mid-frame must not leak into the frame.
        rx_q.delete();
        rp_count = 0;
        sensor_iterations = cnt_p;
        data_avl = 1'b1;
        wait_bytes(12, 200, "chg");
        sensor_iterations = {272{1'b1}};
        wait_rp(1, 600, "chg");
        data_avl = 1'b0;
        repeat (3) @(negedge clk_12MHz);
        check_frame(cnt_p, 0, "chg");
        $display("[TB] frame chg: %0d bytes, input forced to FF mid-frame", rx_q.size());

        // Reset in the middle of the payload abandons the frame silently.
        rx_q.delete();
        rp_count = 0;
        sensor_iterations = cnt_p;
        data_avl = 1'b1;
        wait_bytes(22, 200, "mid");
        reset = 1'b1;
        data_avl = 1'b0;
        @(negedge clk_12MHz);
        check_eq("mid_valid", {31'd0, byte_valid}, 32'd0);
        check_eq("mid_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        repeat (60) @(negedge clk_12MHz);
        check_eq("mid_rp", 32'(rp_count), 32'd0);
        $display("[TB] frame mid-reset: abandoned after %0d bytes", rx_q.size());
        run_frame(cnt_p, "after");
        $display("[TB] frame after: %0d bytes, %0d pulses", rx_q.size(), rp_count);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
